// File: rtl/uart_rx_pkg.sv
// Shared types for the host-to-core UART link.
//   uart_res_t : acknowledgement request sent to the TX controller
//   START_FLAG : first byte of every host frame
package uart_rx_pkg;

  typedef enum logic [1:0] {
    RES_NONE = 2'd0,
    RES_ACK  = 2'd1,
    RES_NAK  = 2'd2
  } uart_res_t;

  localparam logic [7:0] START_FLAG = 8'hA5;

endpackage

// File: rtl/uart_rx_ctrl.sv
// Byte-level frame parser for the host-to-core UART link.
// Frame: START_FLAG, CMD, LEN, PAYLOAD[LEN], CHECKSUM (8-bit wrapping sum of
// every preceding byte of the frame).
// Ports:
//   clk, rstn    : clock, synchronous active-low reset
//   rx_data      : byte from the UART RX PHY, qualified by rx_valid
//   cmd_valid    : one-cycle pulse, accepted command on cmd_code/len/payload
//   cmd_code     : CMD byte of the last accepted frame (held)
//   cmd_len      : LEN byte of the last accepted frame (held)
//   cmd_payload  : payload, byte i at [i*8 +: 8], unused bytes 0 (held)
//   res          : one-cycle RES_ACK / RES_NAK towards the TX controller
module uart_rx_ctrl
  import uart_rx_pkg::*;
#(
  parameter int MAX_LEN        = 4,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [7:0]           rx_data,
  input  logic                 rx_valid,
  output logic                 cmd_valid,
  output logic [7:0]           cmd_code,
  output logic [7:0]           cmd_len,
  output logic [MAX_LEN*8-1:0] cmd_payload,
  output uart_res_t            res
);

  localparam int              TW        = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0]   TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]      MAX_LEN_B = 8'(MAX_LEN);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_LEN,
    S_PAYLOAD,
    S_CHECKSUM
  } state_t;

  state_t                 state;
  logic [7:0]             chk;
  logic [7:0]             code_q;
  logic [7:0]             len_q;
  logic [7:0]             byte_cnt;
  logic [TW-1:0]          tmo_cnt;
  logic [MAX_LEN*8-1:0]   pay_buf;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // branch below reads the values from before this edge.
    if (!rstn) begin
      // NOTE: the payload buffer is an ordinary register here and is cleared
      // with everything else, so no stale bytes can leak into cmd_payload.
      state       <= S_IDLE;
      chk         <= '0;
      code_q      <= '0;
      len_q       <= '0;
      byte_cnt    <= '0;
      tmo_cnt     <= '0;
      pay_buf     <= '0;
      cmd_valid   <= 1'b0;
      cmd_code    <= '0;
      cmd_len     <= '0;
      cmd_payload <= '0;
      res         <= RES_NONE;
    end else begin
      // Pulse outputs default low; a branch below may raise them for one cycle.
      cmd_valid <= 1'b0;
      res       <= RES_NONE;

      if (rx_valid) begin
        // A byte always beats a coincident timeout.
        tmo_cnt <= '0;
        unique case (state)
          S_IDLE: begin
            // Resync hunt: anything but START_FLAG is silently dropped.
            if (rx_data == START_FLAG) begin
              chk     <= START_FLAG;
              pay_buf <= '0;
              state   <= S_CMD;
            end
          end
          S_CMD: begin
            code_q <= rx_data;
            chk    <= chk + rx_data;
            state  <= S_LEN;
          end
          S_LEN: begin
            if (rx_data > MAX_LEN_B) begin
              res   <= RES_NAK;
              state <= S_IDLE;
            end else begin
              len_q    <= rx_data;
              byte_cnt <= '0;
              chk      <= chk + rx_data;
              state    <= (rx_data == 8'd0) ? S_CHECKSUM : S_PAYLOAD;
            end
          end
          S_PAYLOAD: begin
            for (int i = 0; i < MAX_LEN; i++) begin
              if (byte_cnt == 8'(i)) pay_buf[i*8 +: 8] <= rx_data;
            end
            chk      <= chk + rx_data;
            byte_cnt <= byte_cnt + 8'd1;
            if (byte_cnt == len_q - 8'd1) state <= S_CHECKSUM;
          end
          S_CHECKSUM: begin
            if (rx_data == chk) begin
              cmd_valid   <= 1'b1;
              cmd_code    <= code_q;
              cmd_len     <= len_q;
              cmd_payload <= pay_buf;
              res         <= RES_ACK;
            end else begin
              res <= RES_NAK;
            end
            state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end else if (state == S_IDLE) begin
        tmo_cnt <= '0;
      end else if (tmo_cnt == TMO_LAST) begin
        // Host went quiet mid-frame: abandon it and tell the host.
        res     <= RES_NAK;
        state   <= S_IDLE;
        tmo_cnt <= '0;
      end else begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
    end
  end

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
- Byte-level frame parser for the host-to-core UART link. The receive-side counterpart of the TX framer.
- Consumes bytes from the UART RX PHY and validates frames of the form START_FLAG, CMD, LEN, PAYLOAD[LEN], CHECKSUM.
- Presents each accepted command to the core-side command logic.
- Drives res (RES_ACK / RES_NAK) straight into the TX controller, which returns the acknowledgement frame to the host.

Parameters:
- MAX_LEN, 4: maximum payload bytes per frame; the payload buffer is MAX_LEN*8 bits.
- TIMEOUT_CYCLES, 1000000: idle clk cycles allowed between bytes inside a frame before it is aborted.

Ports:
- clk  input  1  clock
- rstn  input  1  reset, synchronous, active-low
- rx_data  input  8  received byte from the UART RX PHY
- rx_valid  input  1  one-cycle strobe; rx_data is valid
- cmd_valid  output  1  one-cycle pulse; an accepted command is presented
- cmd_code  output  8  CMD byte of the accepted frame
- cmd_len  output  8  LEN byte of the accepted frame
- cmd_payload  output  MAX_LEN*8  payload, little-endian (byte i at bits [i*8 +: 8]); unused bytes are 0
- res  output  uart_res_t  RES_ACK / RES_NAK for one cycle, otherwise RES_NONE

Behaviour:
- Reset (synchronous, rstn low at a clk edge) clears all state:
  - cmd_valid=0, cmd_code=0, cmd_len=0, cmd_payload=0, res=RES_NONE.
  - FSM=IDLE; checksum, byte counter and timeout counter = 0.
  - A frame in progress at reset is discarded silently; no res is emitted.
- FSM states: IDLE, CMD, LEN, PAYLOAD, CHECKSUM. Each transition is taken only on a cycle with rx_valid=1.
- IDLE:
  - rx_data==START_FLAG: checksum<=START_FLAG, payload buffer<=0, go to CMD.
  - Any other byte is dropped; this is the resync hunt, with no res.
- CMD: latch the byte, checksum+=byte, go to LEN.
- LEN:
  - byte>MAX_LEN: res=RES_NAK, go to IDLE.
  - byte==0: checksum+=0, go to CHECKSUM.
  - Otherwise: latch len, counter<=0, checksum+=byte, go to PAYLOAD.
- PAYLOAD:
  - Store the byte at buffer[counter*8 +: 8], checksum+=byte, counter+=1.
  - When counter==len-1, go to CHECKSUM.
- CHECKSUM:
  - byte==checksum: next cycle cmd_valid=1, cmd_code/cmd_len/cmd_payload update, and res=RES_ACK in the same cycle.
  - Otherwise: next cycle res=RES_NAK; cmd_* outputs keep their previous values and cmd_valid=0.
  - In both cases go to IDLE.
- Checksum arithmetic: 8-bit, sums wrap mod 256. It covers START, CMD, LEN and the payload bytes, and excludes the checksum byte itself.
- Latency: cmd_valid/res assert exactly 1 clk after the rx_valid cycle carrying the checksum byte. cmd_valid and res are single-cycle pulses.
- Output hold: cmd_code, cmd_len and cmd_payload hold until the next accepted frame.
- Timeout:
  - Counter runs in any state other than IDLE. It resets to 0 on every rx_valid and in IDLE.
  - On reaching TIMEOUT_CYCLES-1 with no rx_valid: res=RES_NAK for one cycle, go to IDLE, no cmd_valid.
  - If rx_valid arrives in the same cycle the timeout would fire, the byte wins: it is processed and the counter clears.
- A START_FLAG value appearing inside CMD, LEN, PAYLOAD or CHECKSUM is treated as data. There is no escaping.
- Back-to-back frames: a START byte arriving the cycle after a CHECKSUM byte is accepted. IDLE is entered on that same edge, so there are no dead cycles.
- res is never RES_ACK and RES_NAK at once. At most one res pulse per frame.
- Bytes arriving while a res pulse is being driven are parsed normally.

Test Plan:
- Valid frame: START_FLAG, 8'h01, 8'h04, 8'h78, 8'h56, 8'h34, 8'h12, chk = (START_FLAG+8'h01+8'h04+8'h78+8'h56+8'h34+8'h12) mod 256.
  - Required: 1 clk after chk, cmd_valid=1 for 1 cycle, cmd_code=8'h01, cmd_len=8'h04, cmd_payload=32'h12345678, res=RES_ACK for 1 cycle.
- Zero-length frame: START_FLAG, 8'h02, 8'h00, chk = (START_FLAG+8'h02) mod 256.
  - Required: cmd_valid pulse, cmd_len=0, cmd_payload=0, RES_ACK.
- Bad checksum: the valid frame above with chk+1.
  - Required: res=RES_NAK for 1 cycle, cmd_valid stays 0, cmd_* retain prior values.
- LEN=8'h05 with MAX_LEN=4.
  - Required: RES_NAK 1 clk after the LEN byte. A following correct frame is accepted with RES_ACK.
- Timeout: TIMEOUT_CYCLES=16, send START_FLAG, 8'h01, then silence.
  - Required: RES_NAK at the 16th idle cycle, FSM in IDLE.
  - A byte arriving on exactly that cycle instead suppresses the NAK and advances parsing.
- Garbage and reset:
  - 8'h00, 8'hFF before START_FLAG are ignored, and the frame is then parsed correctly.
  - rstn low mid-payload returns all outputs to reset values with no res. A fresh valid frame then ACKs.
